// File: rtl/if_fetch_pkg.sv
// Shared constants and state encodings for the instruction-fetch stage.
package if_fetch_pkg;

  localparam logic        rstEnable  = 1'b1;
  localparam logic        chipEnable = 1'b1;
  localparam logic [31:0] ZERO32     = 32'h0000_0000;
  localparam int          INST_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_assembler.sv
// Collects the four returned bytes of one fetch and packs them little-endian.
module inst_assembler
  import if_fetch_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_capture,
  input  logic [7:0]  i_byte,
  output logic        o_last,
  output logic [31:0] o_word
);

  logic [7:0] r_b0, r_b1, r_b2;
  logic [1:0] r_recv_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst == rstEnable) begin
      r_b0       <= '0;
      r_b1       <= '0;
      r_b2       <= '0;
      r_recv_idx <= '0;
    end else if (i_clear) begin
      r_recv_idx <= '0;
    end else if (i_capture) begin
      unique case (r_recv_idx)
        2'd0:    r_b0 <= i_byte;
        2'd1:    r_b1 <= i_byte;
        2'd2:    r_b2 <= i_byte;
        default: ;
      endcase
      r_recv_idx <= r_recv_idx + 2'd1;
    end
  end

  // Byte 3 is never buffered: it goes straight into the packed word.
  assign o_last = i_capture && (r_recv_idx == 2'd3);
  assign o_word = {i_byte, r_b2, r_b1, r_b0};

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: samples the PC, reads four bytes, hands {pc, inst} to IF/ID.
// state | meaning
// IDLE  | sample pc_in, pulse pc_taken_out
// FETCH | issue byte requests, capture returned bytes
// HOLD  | present inst_valid_out until IF/ID accepts
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  pc_taken_out,
  input  logic                  branch_flag_in,
  output logic                  mem_req_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic                  mem_grant_in,
  input  logic [7:0]            mem_data_in,
  input  logic                  stall_in,
  output logic                  inst_valid_out,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc_out
);

  fetch_state_e          r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [2:0]            r_issue_idx;
  logic                  r_accept_d;
  logic                  r_valid;
  logic [INST_WIDTH-1:0] r_inst;
  logic [ADDR_WIDTH-1:0] r_inst_pc;

  logic        w_run, w_live, w_req, w_accept, w_capture, w_clear, w_xfer, w_last;
  logic [31:0] w_word;

  assign w_run     = (rdy_in == chipEnable) && (rst_in != rstEnable);
  assign w_live    = w_run && !branch_flag_in;
  assign w_req     = w_live && (r_state == FETCH) && (r_issue_idx < 3'(INST_BYTES));
  assign w_accept  = w_req && mem_grant_in;
  assign w_capture = w_live && (r_state == FETCH) && r_accept_d;
  assign w_clear   = w_run && ((r_state == IDLE) || branch_flag_in);
  assign w_xfer    = w_live && (r_state == HOLD) && r_valid && !stall_in;

  assign pc_taken_out   = w_live && (r_state == IDLE);
  assign mem_req_out    = w_req;
  assign mem_addr_out   = r_fetch_pc + ADDR_WIDTH'(r_issue_idx);
  assign inst_valid_out = r_valid;
  assign inst_out       = r_inst;
  assign inst_pc_out    = r_inst_pc;

  inst_assembler u_asm (
    .i_clk     (clk_in),
    .i_rst     (rst_in),
    .i_clear   (w_clear),
    .i_capture (w_capture),
    .i_byte    (mem_data_in),
    .o_last    (w_last),
    .o_word    (w_word)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in == rstEnable) r_state <= IDLE;
    else if (w_run)          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (branch_flag_in) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    w_next = FETCH;
        FETCH:   if (w_last) w_next = HOLD;
        HOLD:    if (w_xfer) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in == rstEnable) begin
      r_fetch_pc  <= '0;
      r_issue_idx <= '0;
      r_accept_d  <= 1'b0;
      r_valid     <= 1'b0;
      r_inst      <= ZERO32;
      r_inst_pc   <= '0;
    end else if (w_run) begin
      r_accept_d <= w_accept;
      if (branch_flag_in) begin
        r_issue_idx <= '0;
        r_valid     <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_fetch_pc  <= pc_in;
            r_issue_idx <= '0;
          end
          FETCH: begin
            if (w_accept) r_issue_idx <= r_issue_idx + 3'd1;
            if (w_last) begin
              r_inst    <= w_word;
              r_inst_pc <= r_fetch_pc;
              r_valid   <= 1'b1;
            end
          end
          HOLD: if (w_xfer) r_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios then random traffic, checked against a transaction-level model.
module tb_if_fetch;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, branch_flag_in, mem_grant_in, stall_in;
  logic [31:0] pc_in;
  logic [7:0]  mem_data_in;
  logic        pc_taken_out, mem_req_out, inst_valid_out;
  logic [31:0] mem_addr_out, inst_out, inst_pc_out;

  if_fetch dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .pc_in          (pc_in),
    .pc_taken_out   (pc_taken_out),
    .branch_flag_in (branch_flag_in),
    .mem_req_out    (mem_req_out),
    .mem_addr_out   (mem_addr_out),
    .mem_grant_in   (mem_grant_in),
    .mem_data_in    (mem_data_in),
    .stall_in       (stall_in),
    .inst_valid_out (inst_valid_out),
    .inst_out       (inst_out),
    .inst_pc_out    (inst_pc_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errs   = 0;

  // model: one fetch "transaction" at a time
  bit          m_busy, m_valid, m_pend, m_rst_prev;
  logic [31:0] m_pc;
  int          m_iss, m_recv;
  logic [31:0] br_target;

  bit          s_taken, s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_pc;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'h0: return 8'h13;
      32'h1: return 8'h00;
      32'h2: return 8'h50;
      32'h3: return 8'h00;
      default: begin
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ a[7:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit          acc, ov, exp_taken, exp_req;
    logic [31:0] acc_addr, npc;
    @(negedge clk_in);
    s_taken = pc_taken_out;
    s_req   = mem_req_out;
    s_addr  = mem_addr_out;
    s_valid = inst_valid_out;
    s_inst  = inst_out;
    s_pc    = inst_pc_out;
    acc      = mem_req_out && mem_grant_in && rdy_in;
    acc_addr = mem_addr_out;
    npc      = pc_in;
    if (rst_in) begin
      chk("rst_taken", 32'(s_taken), 32'd0);
      chk("rst_req", 32'(s_req), 32'd0);
      if (m_rst_prev) begin
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_inst", s_inst, 32'd0);
        chk("rst_inst_pc", s_pc, 32'd0);
        chk("rst_addr", s_addr, 32'd0);
      end
      m_busy = 0; m_valid = 0; m_pend = 0; m_iss = 0; m_recv = 0;
      m_rst_prev = 1;
    end else begin
      m_rst_prev = 0;
      exp_taken = rdy_in && !branch_flag_in && !m_busy;
      exp_req   = rdy_in && !branch_flag_in && m_busy && (m_iss < 4);
      chk("taken", 32'(s_taken), 32'(exp_taken));
      chk("req", 32'(s_req), 32'(exp_req));
      chk("valid", 32'(s_valid), 32'(m_valid));
      if (exp_req) chk("addr", s_addr, m_pc + 32'(m_iss));
      if (m_valid) begin
        chk("inst", s_inst, word_at(m_pc));
        chk("inst_pc", s_pc, m_pc);
      end
      if (rdy_in) begin
        if (branch_flag_in) begin
          m_busy = 0; m_valid = 0; m_pend = 0; m_iss = 0; m_recv = 0;
          npc = br_target;
        end else if (!m_busy) begin
          m_busy = 1; m_pc = pc_in; m_iss = 0; m_recv = 0; m_pend = 0;
          npc = pc_in + 32'd4;
        end else begin
          ov = m_valid;
          if (m_pend) begin
            m_recv++;
            if (m_recv == 4) m_valid = 1;
          end
          m_pend = exp_req && mem_grant_in;
          if (m_pend) m_iss++;
          if (ov && !stall_in) begin
            m_valid = 0;
            m_busy  = 0;
          end
        end
      end
    end
    @(posedge clk_in);
    #1;
    if (acc) mem_data_in = mem_byte(acc_addr);
    pc_in = npc;
  endtask

  task automatic wait_taken(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_taken && n < 30);
    chk("wait_taken", 32'(s_taken), 32'd1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_valid && n < 40);
    chk("wait_valid", 32'(s_valid), 32'd1);
  endtask

  initial begin
    int          n;
    logic [31:0] held;
    logic [31:0] wrap_a [4];
    wrap_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

    rst_in = 1; rdy_in = 1; branch_flag_in = 0; mem_grant_in = 1; stall_in = 0;
    pc_in = 32'h0; mem_data_in = 8'h00; br_target = 32'h0;
    m_busy = 0; m_valid = 0; m_pend = 0; m_rst_prev = 0; m_iss = 0; m_recv = 0; m_pc = 0;

    // basic fetch at 0
    repeat (3) tick();
    rst_in = 0;
    tick();
    chk("first_sample", 32'(s_taken), 32'd1);
    wait_valid(n);
    chk("lat_basic", 32'(n), 32'd6);
    chk("inst_basic", s_inst, 32'h0050_0013);
    chk("pc_basic", s_pc, 32'h0);

    // grant withheld twice on byte 1
    tick();
    chk("taken_after_xfer", 32'(s_taken), 32'd1);
    tick();
    mem_grant_in = 0;
    tick();
    chk("gap_addr_a", s_addr, 32'h5);
    tick();
    chk("gap_addr_b", s_addr, 32'h5);
    mem_grant_in = 1;
    tick();
    chk("gap_addr_c", s_addr, 32'h5);
    wait_valid(n);
    chk("lat_gnt_gap", 32'(n) + 32'd4, 32'd8);
    chk("inst_gap", s_inst, word_at(32'h4));

    // stall for three valid cycles
    wait_taken(n);
    stall_in = 1;
    wait_valid(n);
    held = s_inst;
    repeat (2) begin
      tick();
      chk("stall_inst", s_inst, held);
      chk("stall_req", 32'(s_req), 32'd0);
      chk("stall_taken", 32'(s_taken), 32'd0);
    end
    stall_in = 0;
    tick();
    chk("stall_release_taken", 32'(s_taken), 32'd0);
    tick();
    chk("taken_after_stall", 32'(s_taken), 32'd1);

    // branch to 0x100 after two bytes issued
    tick();
    tick();
    branch_flag_in = 1; br_target = 32'h100;
    tick();
    branch_flag_in = 0;
    tick();
    chk("br_resample", 32'(s_taken), 32'd1);
    wait_valid(n);
    chk("br_inst_pc", s_pc, 32'h100);
    chk("br_inst", s_inst, word_at(32'h100));

    // rdy low mid-fetch
    wait_taken(n);
    tick();
    tick();
    rdy_in = 0;
    repeat (4) begin
      tick();
      chk("frz_req", 32'(s_req), 32'd0);
    end
    rdy_in = 1;
    wait_valid(n);
    chk("frz_inst", s_inst, word_at(32'h104));
    chk("frz_pc", s_pc, 32'h104);

    // redirect to the top of the address space
    branch_flag_in = 1; br_target = 32'hFFFF_FFFE;
    tick();
    branch_flag_in = 0;
    tick();
    chk("wrap_sample", 32'(s_taken), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wrap_addr", s_addr, wrap_a[i]);
    end
    wait_valid(n);
    chk("wrap_pc", s_pc, 32'hFFFF_FFFE);

    // reset in the middle of a fetch
    wait_taken(n);
    tick();
    tick();
    rst_in = 1;
    tick();
    tick();
    rst_in = 0;
    pc_in = 32'h40;
    tick();
    chk("post_rst_sample", 32'(s_taken), 32'd1);
    wait_valid(n);
    chk("post_rst_pc", s_pc, 32'h40);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      mem_grant_in   = ($urandom_range(0, 3) != 0);
      stall_in       = ($urandom_range(0, 2) == 0);
      rdy_in         = ($urandom_range(0, 7) != 0);
      branch_flag_in = ($urandom_range(0, 39) == 0);
      br_target      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                                   : $urandom;
      rst_in         = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst_in = 0; rdy_in = 1; branch_flag_in = 0; stall_in = 0; mem_grant_in = 1;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
